// File: rtl/ram_readback_streamer.sv
// Capture-RAM read-back engine: walks every RAM word and streams its slices.
// Optional: define READBACK_CHECKSUM_EN to append a modulo-2^W sum beat.
module ram_readback_streamer #(
  parameter int no_of_digits    = 10,
  parameter int radix_bits      = 3,
  parameter int address_width   = 14,
  parameter int max_ram_address = 4096,
  parameter int burst_index     = 5,
  parameter int read_latency    = 2,
  localparam int W = (no_of_digits + 1) * radix_bits
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       start,
  output logic [address_width-1:0]   ram_addr,
  input  logic [W*burst_index-1:0]   ram_q,
  output logic [W-1:0]               dout,
  output logic                       dout_valid,
  input  logic                       dout_ready,
  output logic                       dout_last,
  output logic                       busy,
  output logic                       done
);

  localparam int IDX_W = $clog2(burst_index + 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(burst_index - 1);
  localparam logic [address_width-1:0] LAST_ADDR =
    address_width'(max_ram_address - 1);
  localparam logic [1:0] WAIT_LAST = 2'(read_latency - 1);

  typedef enum logic [2:0] {
    IDLE, ADDR, WAIT, LOAD, SEND, DONE
  } state_t;

  state_t                     r_state;
  logic [address_width-1:0]   r_cnt;
  logic [address_width-1:0]   r_addr;
  logic [1:0]                 r_wait;
  logic [IDX_W-1:0]           r_idx;
  logic [W*burst_index-1:0]   r_buf;
  logic [W-1:0]               r_dout;
  logic                       r_valid;
  logic                       r_last;
  logic                       r_busy;
  logic                       r_done;
`ifdef READBACK_CHECKSUM_EN
  logic [W-1:0]               r_sum;
  logic                       r_csum;
`endif

  logic                       w_accept;
  logic                       w_last_slice;
  logic                       w_last_word;
  logic [IDX_W-1:0]           w_next_idx;
  logic [W-1:0]               w_next_slice;

  assign w_accept     = r_valid && dout_ready;
  assign w_last_slice = (r_idx == LAST_IDX);
  assign w_last_word  = (r_cnt == LAST_ADDR);
  assign w_next_idx   = r_idx + 1'b1;
  assign w_next_slice = r_buf[int'(w_next_idx)*W +: W];

  assign ram_addr   = r_addr;
  assign dout       = r_dout;
  assign dout_valid = r_valid;
  assign dout_last  = r_last;
  assign busy       = r_busy;
  assign done       = r_done;

  // Read-back sequencer: address, wait out RAM latency, unpack, stream.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_addr  <= '0;
      r_wait  <= '0;
      r_idx   <= '0;
      r_buf   <= '0;
      r_dout  <= '0;
      r_valid <= 1'b0;
      r_last  <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
`ifdef READBACK_CHECKSUM_EN
      r_sum   <= '0;
      r_csum  <= 1'b0;
`endif
    end else begin
      case (r_state)
        IDLE: begin
          r_done <= 1'b0;
          if (start) begin
            r_busy  <= 1'b1;
            r_cnt   <= '0;
            r_addr  <= '0;
            r_state <= ADDR;
`ifdef READBACK_CHECKSUM_EN
            r_sum   <= '0;
`endif
          end
        end
        ADDR: begin
          r_wait  <= '0;
          r_state <= WAIT;
        end
        WAIT: begin
          if (r_wait == WAIT_LAST) r_state <= LOAD;
          else r_wait <= r_wait + 1'b1;
        end
        LOAD: begin
          r_buf   <= ram_q;
          r_idx   <= '0;
          r_dout  <= ram_q[W-1:0];
          r_valid <= 1'b1;
          r_state <= SEND;
`ifdef READBACK_CHECKSUM_EN
          r_csum  <= 1'b0;
          r_last  <= 1'b0;
`else
          r_last  <= w_last_word && (LAST_IDX == '0);
`endif
        end
        SEND: begin
          if (w_accept) begin
`ifdef READBACK_CHECKSUM_EN
            r_sum <= r_sum + r_dout;
            if (r_csum) begin
              r_valid <= 1'b0;
              r_last  <= 1'b0;
              r_done  <= 1'b1;
              r_state <= DONE;
            end else if (!w_last_slice) begin
              r_idx  <= w_next_idx;
              r_dout <= w_next_slice;
            end else if (w_last_word) begin
              r_csum <= 1'b1;
              r_dout <= r_sum + r_dout;
              r_last <= 1'b1;
            end else begin
              r_valid <= 1'b0;
              r_cnt   <= r_cnt + 1'b1;
              r_addr  <= r_cnt + 1'b1;
              r_state <= ADDR;
            end
`else
            if (!w_last_slice) begin
              r_idx  <= w_next_idx;
              r_dout <= w_next_slice;
              r_last <= w_last_word && (w_next_idx == LAST_IDX);
            end else if (w_last_word) begin
              r_valid <= 1'b0;
              r_last  <= 1'b0;
              r_done  <= 1'b1;
              r_state <= DONE;
            end else begin
              r_valid <= 1'b0;
              r_cnt   <= r_cnt + 1'b1;
              r_addr  <= r_cnt + 1'b1;
              r_state <= ADDR;
            end
`endif
          end
        end
        DONE: begin
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule
